// File: rtl/gpin_filter.sv
// Pin input conditioner: synchroniser, shared prescaled sample tick and per-bit debounce.
// Optional macro GPIN_FILTER_EDGE_EN adds the per-bit oRISE/oFALL edge pulse outputs.
module gpin_filter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 1000,
    parameter int STABLE      = 4
) (
    input  logic             iCLK,
    input  logic             iRSTN,
    input  logic [WIDTH-1:0] iPIN,
    input  logic             iEN,
    output logic [WIDTH-1:0] oGPIN,
    output logic             oCHG
`ifdef GPIN_FILTER_EDGE_EN
    ,
    output logic [WIDTH-1:0] oRISE,
    output logic [WIDTH-1:0] oFALL
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [PW-1:0]                     pre_cnt;
    logic                              tick;
    logic [WIDTH-1:0][CW-1:0]          cnt;
    logic [WIDTH-1:0][CW-1:0]          cnt_nxt;
    logic [WIDTH-1:0]                  gpin_nxt;

    // Synchroniser: the only logic that samples the raw pins
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iPIN};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Prescaler restarts from 0 whenever debouncing is re-enabled
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            pre_cnt <= '0;
        end else if (!iEN || pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = iEN && (pre_cnt == PRE_LAST);

    always_comb begin
        gpin_nxt = oGPIN;
        cnt_nxt  = cnt;
        if (!iEN) begin
            gpin_nxt = sync;
            cnt_nxt  = '0;
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                // A sample matching the current output restarts the run
                if (sync[i] == oGPIN[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    gpin_nxt[i] = sync[i];
                    cnt_nxt[i]  = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Output stage: pulses are derived from the next value so they align with the oGPIN update
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            cnt   <= '0;
            oGPIN <= '0;
            oCHG  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            oGPIN <= gpin_nxt;
            oCHG  <= |(gpin_nxt ^ oGPIN);
        end
    end

`ifdef GPIN_FILTER_EDGE_EN
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oRISE <= '0;
            oFALL <= '0;
        end else begin
            oRISE <= gpin_nxt & ~oGPIN;
            oFALL <= ~gpin_nxt & oGPIN;
        end
    end
`endif

endmodule

// File: doc/gpin_filter.md
# gpin_filter

Input-conditioning stage that sits directly upstream of the GPIO core's `iGPIN` port. It synchronises up to 32 asynchronous pin inputs into the `iCLK` domain and debounces each bit with a shared prescaled sample tick. It delivers clean, glitch-free levels so that the core's level-sensitive interrupt logic never sees metastable or bouncing inputs. A one-cycle change pulse is also produced for optional event logging.

## Interface
- `WIDTH`, 32: number of pin bits filtered.
- `SYNC_STAGES`, 2: synchroniser flop depth, ≥2.
- `PRESCALE`, 1000: clock cycles per sample tick, ≥1.
- `STABLE`, 4: consecutive differing samples required to accept a new level, ≥1.

Ports:
- `iCLK`  in  1  system clock; one clock domain, all flops on rising edge.
- `iRSTN`  in  1  asynchronous, active-low reset.
- `iPIN`  in  WIDTH  raw asynchronous pin levels.
- `iEN`  in  1  1 = debounce active; 0 = bypass (synchronised only).
- `oGPIN`  out  WIDTH  filtered levels; connects to GPIO core `iGPIN`.
- `oCHG`  out  1  one-cycle pulse when any `oGPIN` bit changed on this edge.

## Operation
- **Reset:** while `iRSTN`=0, clear all state asynchronously: synchroniser flops, prescaler, per-bit counters, `oGPIN`, `oCHG` and edge outputs. All outputs read 0 during reset.
- **Synchroniser:** `sync` = `iPIN` after `SYNC_STAGES` flops. No other logic samples `iPIN`.
- **Prescaler:**
  - Counter `0..PRESCALE-1`; `tick`=1 when count==`PRESCALE-1`, then wraps to 0.
  - `PRESCALE`=1 gives a tick every cycle.
  - Held at 0 while `iEN`=0.
- **Per-bit counter `cnt[i]`:** width `$clog2(STABLE+1)`. On `tick`, with `iEN`=1:
  - `sync[i]==oGPIN[i]` → `cnt[i]`←0 (a glitch that reverts restarts the count).
  - Else if `cnt[i]==STABLE-1` → `oGPIN[i]`←`sync[i]`, `cnt[i]`←0.
  - Else `cnt[i]`←`cnt[i]+1`.
  - Between ticks, `cnt[i]` holds.
- **Bypass (`iEN`=0):** every cycle `oGPIN`←`sync`, all `cnt` forced to 0.
- **Re-enable (`iEN` 0→1):** `oGPIN` is unchanged. Prescaler and counters restart from 0.
- **Change pulse:** `oCHG` is registered: 1 in the cycle where `oGPIN` differs from its previous value, otherwise 0. Multiple bits changing on the same edge produce one pulse.
- **Independence:** bits are independent; simultaneous acceptance on several bits is allowed.

## Timing
- **Bypass latency:** `iPIN` to `oGPIN` = `SYNC_STAGES`+1 cycles.
- **Debounce latency:** measured from `sync` change to `oGPIN` update.
  - Minimum `(STABLE-1)*PRESCALE+1` cycles.
  - Maximum `STABLE*PRESCALE` cycles.
  - Add `SYNC_STAGES` for latency from the pin.
- **Change pulse alignment:** `oCHG` and edge pulses are asserted on the same edge that updates `oGPIN` and last exactly one cycle.
- **Reset mid-count:** partial counts are lost. After release, a pin held high reaches `oGPIN` only after full debounce latency.
- **No reset-release spike:** no pulse on `oCHG` at reset release unless a bit actually changes from 0.

## Configuration
- **Macro `GPIN_FILTER_EDGE_EN`:**
  - **Defined:** adds ports `oRISE` (out, `WIDTH`) and `oFALL` (out, `WIDTH`).
    - `oRISE[i]`=1 for one cycle when `oGPIN[i]` goes 0→1.
    - `oFALL[i]`=1 for one cycle when `oGPIN[i]` goes 1→0.
    - Both are registered, aligned with `oCHG`, and reset to 0.
  - **Undefined:** ports and their logic are absent; all other behaviour is identical.

## Test plan
Parameters: `WIDTH`=32, `SYNC_STAGES`=2, `PRESCALE`=4, `STABLE`=3, `iEN`=1 unless stated.
- **Reset:** `iPIN`=0xFFFFFFFF with `iRSTN` low → `oGPIN`=0 and `oCHG`=0. After release, `oGPIN`=0xFFFFFFFF within 2+12 cycles, with exactly one `oCHG` pulse.
- **Glitch rejection:** `iPIN[5]`=1 for 8 cycles, then 0 → `oGPIN` stays 0x00000000 and `oCHG` never asserts.
- **Stable edge:** `iPIN[0]` 0→1 and held → `oGPIN`=0x00000001 between 11 and 14 cycles after the pin change, with a single-cycle `oCHG`.
- **Bypass:** `iEN`=0 and `iPIN` stepped to 0x000000A5 → `oGPIN`=0x000000A5 exactly 3 cycles later, with `oCHG` pulsing once. Then set `iEN`=1 and drop `iPIN` to 0 → `oGPIN` holds 0x000000A5 for at least 9 cycles.
- **Reset mid-count:** `iPIN[7]`=1, assert `iRSTN` low after 2 ticks for 1 cycle, then release → `oGPIN[7]` rises no earlier than 2+9 cycles after release.
- **Edge outputs (`GPIN_FILTER_EDGE_EN`):** `iPIN[3]` 0→1→0, each level held 20 cycles → `oRISE`=0x00000008 for one cycle, then later `oFALL`=0x00000008 for one cycle. Each pulse is coincident with `oCHG`.
